// File: rtl/pipeline_mips32_hz.sv
// 5-stage MIPS32 subset core (IF/ID/EX/MEM/WB) with EX/MEM and MEM/WB
// forwarding, load-use stall, BEQ flush, HALT, program-load port, debug
// register read port and retire counter.
module pipeline_mips32_hz #(
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024,
  parameter bit FWD_EN     = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable_ex,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic [4:0]                    dbg_reg_addr,
  output logic [DATA_W-1:0]             dbg_reg_data,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic                          stall,
  output logic                          flush,
  output logic                          halted,
  output logic [31:0]                   retire_cnt
);
  localparam int PC_W = $clog2(IMEM_DEPTH);
  localparam int DA_W = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW  = 6'b100011, OP_SW   = 6'b101011,
                         OP_ADDI  = 6'b001000, OP_BEQ = 6'b000100, OP_HALT = 6'b111111;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100,
                         FN_OR  = 6'b100101, FN_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
                         ALU_OR  = 3'd3, ALU_SLT = 3'd4;

  function automatic logic [DATA_W-1:0] f_alu(input logic [2:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      ALU_SUB: f_alu = a - b;
      ALU_AND: f_alu = a & b;
      ALU_OR:  f_alu = a | b;
      ALU_SLT: f_alu = {{(DATA_W-1){1'b0}}, (sa < sb)};
      default: f_alu = a + b;
    endcase
  endfunction

  // True when a valid, writing, non-r0 producer targets the given source register
  function automatic logic f_hit(input logic vld, input logic wr,
                                 input logic [4:0] dst, input logic [4:0] src);
    f_hit = vld & wr & (dst != 5'd0) & (dst == src);
  endfunction

  logic [31:0]       r_imem [IMEM_DEPTH];
  logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];
  logic [DATA_W-1:0] r_regs [32];

  logic [PC_W-1:0] r_pc;
  logic            r_halted, r_fstop;
  logic [31:0]     r_retire;
  // IF/ID
  logic            r_vld_p1;
  logic [31:0]     r_ir_p1;
  logic [PC_W-1:0] r_pc_p1;
  // ID/EX
  logic              r_vld_p2, r_wr_p2, r_use_imm_p2, r_lw_p2, r_sw_p2, r_beq_p2, r_halt_p2;
  logic [2:0]        r_alu_p2;
  logic [4:0]        r_rs_p2, r_rt_p2, r_dst_p2;
  logic [DATA_W-1:0] r_a_p2, r_b_p2, r_imm_p2;
  logic [PC_W-1:0]   r_pc_p2;
  // EX/MEM
  logic              r_vld_p3, r_wr_p3, r_lw_p3, r_sw_p3, r_halt_p3;
  logic [4:0]        r_dst_p3;
  logic [DATA_W-1:0] r_res_p3, r_st_p3;
  // MEM/WB
  logic              r_vld_p4, r_wr_p4, r_halt_p4;
  logic [4:0]        r_dst_p4;
  logic [DATA_W-1:0] r_wb_p4;

  logic [5:0]        w_op, w_fn;
  logic [4:0]        w_rs, w_rt, w_rd, w_dst;
  logic [DATA_W-1:0] w_imm, w_rs_val, w_rt_val, w_fa, w_fb, w_res;
  logic [2:0]        w_alu;
  logic              w_rd_rs, w_rd_rt, w_wr, w_use_imm, w_lw, w_sw, w_beq, w_halt;
  logic              w_adv, w_wb_we, w_hz, w_lu, w_raw, w_taken, w_id_halt;
  logic [PC_W-1:0]   w_target, w_pc_inc;
  logic [DA_W-1:0]   w_daddr;
  logic              w_unused_bits;

  assign w_adv     = enable_ex & ~r_halted;
  assign w_op      = r_ir_p1[31:26];
  assign w_rs      = r_ir_p1[25:21];
  assign w_rt      = r_ir_p1[20:16];
  assign w_rd      = r_ir_p1[15:11];
  assign w_fn      = r_ir_p1[5:0];
  assign w_imm     = {{(DATA_W-16){r_ir_p1[15]}}, r_ir_p1[15:0]};
  assign w_wb_we   = w_adv & r_vld_p4 & r_wr_p4 & (r_dst_p4 != 5'd0);
  assign w_id_halt = r_vld_p1 & w_halt;
  assign w_pc_inc  = (r_pc == PC_W'(IMEM_DEPTH-1)) ? '0 : r_pc + 1'b1;
  assign w_daddr   = r_res_p3[DA_W-1:0];
  assign w_unused_bits = ^{r_ir_p1[10:6], r_imm_p2[DATA_W-1:PC_W]};

  // ID: decode the instruction held in IF/ID
  always_comb begin
    w_rd_rs = 1'b0; w_rd_rt = 1'b0; w_wr = 1'b0; w_dst = w_rt; w_alu = ALU_ADD;
    w_use_imm = 1'b0; w_lw = 1'b0; w_sw = 1'b0; w_beq = 1'b0; w_halt = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        case (w_fn)
          FN_ADD: begin w_alu = ALU_ADD; w_wr = 1'b1; end
          FN_SUB: begin w_alu = ALU_SUB; w_wr = 1'b1; end
          FN_AND: begin w_alu = ALU_AND; w_wr = 1'b1; end
          FN_OR:  begin w_alu = ALU_OR;  w_wr = 1'b1; end
          FN_SLT: begin w_alu = ALU_SLT; w_wr = 1'b1; end
          default: w_wr = 1'b0;
        endcase
        w_rd_rs = w_wr; w_rd_rt = w_wr; w_dst = w_rd;
      end
      OP_LW:   begin w_rd_rs = 1'b1; w_wr = 1'b1; w_use_imm = 1'b1; w_lw = 1'b1; end
      OP_SW:   begin w_rd_rs = 1'b1; w_rd_rt = 1'b1; w_use_imm = 1'b1; w_sw = 1'b1; end
      OP_ADDI: begin w_rd_rs = 1'b1; w_wr = 1'b1; w_use_imm = 1'b1; end
      OP_BEQ:  begin w_rd_rs = 1'b1; w_rd_rt = 1'b1; w_beq = 1'b1; end
      OP_HALT: w_halt = 1'b1;
      default: w_wr = 1'b0;
    endcase
  end

  // ID: write-first register read and hazard detection
  always_comb begin
    w_rs_val = (w_wb_we && r_dst_p4 == w_rs) ? r_wb_p4 : r_regs[w_rs];
    w_rt_val = (w_wb_we && r_dst_p4 == w_rt) ? r_wb_p4 : r_regs[w_rt];
    w_lu  = (w_rd_rs & f_hit(r_vld_p2, r_wr_p2 & r_lw_p2, r_dst_p2, w_rs)) |
            (w_rd_rt & f_hit(r_vld_p2, r_wr_p2 & r_lw_p2, r_dst_p2, w_rt));
    w_raw = (w_rd_rs & (f_hit(r_vld_p2, r_wr_p2, r_dst_p2, w_rs) |
                        f_hit(r_vld_p3, r_wr_p3, r_dst_p3, w_rs) |
                        f_hit(r_vld_p4, r_wr_p4, r_dst_p4, w_rs))) |
            (w_rd_rt & (f_hit(r_vld_p2, r_wr_p2, r_dst_p2, w_rt) |
                        f_hit(r_vld_p3, r_wr_p3, r_dst_p3, w_rt) |
                        f_hit(r_vld_p4, r_wr_p4, r_dst_p4, w_rt)));
    w_hz  = r_vld_p1 & (FWD_EN ? w_lu : w_raw);
  end

  // EX: operand forwarding (EX/MEM wins over MEM/WB), ALU and branch resolution
  always_comb begin
    w_fa = r_a_p2;
    w_fb = r_b_p2;
    if (FWD_EN) begin
      if (f_hit(r_vld_p4, r_wr_p4, r_dst_p4, r_rs_p2)) w_fa = r_wb_p4;
      if (f_hit(r_vld_p3, r_wr_p3 & ~r_lw_p3, r_dst_p3, r_rs_p2)) w_fa = r_res_p3;
      if (f_hit(r_vld_p4, r_wr_p4, r_dst_p4, r_rt_p2)) w_fb = r_wb_p4;
      if (f_hit(r_vld_p3, r_wr_p3 & ~r_lw_p3, r_dst_p3, r_rt_p2)) w_fb = r_res_p3;
    end
    w_res    = f_alu(r_alu_p2, w_fa, r_use_imm_p2 ? r_imm_p2 : w_fb);
    w_taken  = r_vld_p2 & r_beq_p2 & (w_fa == w_fb);
    w_target = r_pc_p2 + PC_W'(1) + r_imm_p2[PC_W-1:0];
  end

  assign stall        = w_hz & ~w_taken & ~r_halted;
  assign flush        = w_taken & ~r_halted;
  assign halted       = r_halted;
  assign pc           = r_pc;
  assign retire_cnt   = r_retire;
  assign dbg_reg_data = r_regs[dbg_reg_addr];

  // Program-load port; a fetch of the same word this cycle still sees the old value
  always_ff @(posedge clk) begin
    if (imem_we) r_imem[imem_waddr] <= imem_wdata;
  end

  // Control state: PC, stage valid bits, halt, retire counter and register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0; r_fstop <= 1'b0; r_halted <= 1'b0; r_retire <= '0;
      r_vld_p1 <= 1'b0; r_vld_p2 <= 1'b0; r_vld_p3 <= 1'b0; r_vld_p4 <= 1'b0;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_adv) begin
      if (w_taken) begin
        r_pc <= w_target; r_vld_p1 <= 1'b0; r_vld_p2 <= 1'b0;
      end else if (w_hz) begin
        r_vld_p2 <= 1'b0;
      end else if (r_fstop || w_id_halt) begin
        r_vld_p1 <= 1'b0; r_vld_p2 <= r_vld_p1;
        if (w_id_halt) r_fstop <= 1'b1;
      end else begin
        r_pc <= w_pc_inc; r_vld_p1 <= 1'b1; r_vld_p2 <= r_vld_p1;
      end
      r_vld_p3 <= r_vld_p2;
      r_vld_p4 <= r_vld_p3;
      if (r_vld_p4) begin
        r_retire <= r_retire + 32'd1;
        if (r_halt_p4) r_halted <= 1'b1;
      end
      if (w_wb_we) r_regs[r_dst_p4] <= r_wb_p4;
    end
  end

  // Datapath pipeline registers and data memory
  always_ff @(posedge clk) begin
    if (w_adv) begin
      // IF -> IF/ID
      if (!w_hz) begin
        r_ir_p1 <= r_imem[r_pc];
        r_pc_p1 <= r_pc;
      end
      // ID -> ID/EX
      r_a_p2 <= w_rs_val; r_b_p2 <= w_rt_val; r_imm_p2 <= w_imm; r_pc_p2 <= r_pc_p1;
      r_rs_p2 <= w_rs; r_rt_p2 <= w_rt; r_dst_p2 <= w_dst; r_alu_p2 <= w_alu;
      r_wr_p2 <= w_wr; r_use_imm_p2 <= w_use_imm; r_lw_p2 <= w_lw; r_sw_p2 <= w_sw;
      r_beq_p2 <= w_beq; r_halt_p2 <= w_halt;
      // EX -> EX/MEM
      r_res_p3 <= w_res; r_st_p3 <= w_fb; r_dst_p3 <= r_dst_p2; r_wr_p3 <= r_wr_p2;
      r_lw_p3 <= r_lw_p2; r_sw_p3 <= r_sw_p2; r_halt_p3 <= r_halt_p2;
      // MEM -> MEM/WB
      r_wb_p4 <= r_lw_p3 ? r_dmem[w_daddr] : r_res_p3;
      r_dst_p4 <= r_dst_p3; r_wr_p4 <= r_wr_p3; r_halt_p4 <= r_halt_p3;
      if (r_vld_p3 && r_sw_p3) r_dmem[w_daddr] <= r_st_p3;
    end
  end
endmodule

// File: doc/pipeline_mips32_hz.md
Name: pipeline_mips32_hz

Overview:
Parametrised successor to the team's 5-stage MIPS32 pipeline (IF/ID/EX/MEM/WB), with data width, memory depths and forwarding selectable by parameter.
Adds hazard handling: EX/MEM and MEM/WB forwarding, load-use stall, BEQ with flush, and a HALT instruction.
Also adds separate instruction/data memories, a program-load port, a debug register read port and a retire counter.
Top-level core for the processor test benches.

Parameters:
DATA_W, 32, register/ALU/data-memory word width (instruction width fixed at 32)
IMEM_DEPTH, 1024, instruction memory words; PC is word-addressed, width $clog2(IMEM_DEPTH)
DMEM_DEPTH, 1024, data memory words; address = low $clog2(DMEM_DEPTH) bits of ALU result
FWD_EN, 1, 1 = forwarding enabled; 0 = every RAW hazard on an in-flight producer stalls in ID until the producer has left WB

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
enable_ex  in  1  1 = pipeline advances; 0 = every stage, PC and counters hold (memory load port still works)
imem_we  in  1  program-load write strobe
imem_waddr  in  $clog2(IMEM_DEPTH)  program-load address
imem_wdata  in  32  program-load instruction word
dbg_reg_addr  in  5  debug register select
dbg_reg_data  out  DATA_W  combinational REG[dbg_reg_addr]
pc  out  $clog2(IMEM_DEPTH)  current fetch PC
stall  out  1  load-use (or FWD_EN=0 RAW) stall active this cycle
flush  out  1  taken BEQ in EX this cycle
halted  out  1  sticky; set when HALT retires
retire_cnt  out  32  count of non-bubble instructions leaving WB

Behaviour:
- Reset (async, rst_n=0): pc=0; all stage valid bits=0 (bubbles); REG[0..31]=0; stall=flush=halted=0; retire_cnt=0. Memories are not reset. Reset mid-program discards all in-flight instructions.
- ISA:
  - LW 100011 (rt<=M[rs+imm])
  - SW 101011 (M[rs+imm]<=rt)
  - ADDI 001000 (rt<=rs+imm)
  - BEQ 000100
  - R-type 000000 with funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010 (signed, result 1/0)
  - HALT 111111
  - any other opcode or funct = NOP
- imm = sign-extended IR[15:0] to DATA_W. Arithmetic wraps modulo 2^DATA_W. REG[0] reads 0; writes to it are discarded.
- IF: IR <= IMEM[pc]; pc <= pc+1, wrapping at IMEM_DEPTH.
- ID: reads the register file write-first, so a same-cycle WB write is visible.
- Load-use: if ID/EX holds LW with rt≠0, and the ID instruction reads that rt, then for one cycle: pc and IF/ID hold, a bubble goes into ID/EX, stall=1.
  - R-type, SW and BEQ read rs and rt; ADDI and LW read rs only.
- Forwarding (FWD_EN=1): EX operands (including SW store data) take EX/MEM result first, then MEM/WB result, then the ID/EX value.
  - Only from valid writing instructions with destination ≠0. A LW in EX/MEM is never a source.
- BEQ: resolved in EX using forwarded operands.
  - Taken: pc <= BEQ_pc+1+imm; IF/ID and ID/EX become bubbles; flush=1.
  - Not taken: no penalty.
  - Taken branch overrides a concurrent stall.
- HALT: when HALT is in ID, fetch stops (pc holds, bubbles enter ID/EX behind HALT). Older instructions drain.
  - When HALT leaves WB, halted=1. All state is then frozen until reset.
  - A HALT flushed by a taken BEQ has no effect.
- MEM: SW writes DMEM; LW reads DMEM (sync, captured into MEM/WB).
- WB: R-type writes rd; ADDI/LW write rt.
- retire_cnt increments once per valid instruction leaving WB, including HALT; it wraps.
- Simultaneous imem_we while running: the write takes effect on the clock edge; a fetch of the same address in the same cycle returns the old word.

Test Plan:
1. Load ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2; HALT; release reset → r3=12 via EX/MEM and MEM/WB forwarding, stall never 1, halted=1, retire_cnt=4.
2. SW r3→M[4]; LW r4,4(r0); SUB r5,r4,r1 → exactly one stall cycle, r5=7 (12-5).
3. BEQ r1,r1,+2 followed by two ADDI r6 instructions, then ADDI r7,r0,1 → flush pulses once, r6=0, r7=1.
4. SLT with r1=-1, r2=1 → 1; swapped operands → 0. ADD 0x7FFFFFFF+1 → 0x80000000 (wrap).
5. FWD_EN=0 rerun of scenario 1 → same r3=12, stall asserted 3 cycles, retire_cnt=4.
6. Deassert rst_n mid-program, then enable_ex=0 for 5 cycles after restart → outputs return to reset values immediately; pc holds during the freeze; final register state matches a clean run.
